// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared widths, ALU opcodes, FSM state and entry types for the issue stage
package alu_issue_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_MUL = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } entry_t;

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// rtl/alu_issue_stage_fwd_mux.sv - forwarding select for one operand (EX/MEM over MEM/WB over register file)
module alu_issue_stage_fwd_mux
    import alu_issue_stage_pkg::*;
(
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exmem_wr_i,
    input  logic [REG_AW-1:0] exmem_addr_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_wr_i,
    input  logic [REG_AW-1:0] memwb_addr_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] data_o
);

    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    always_comb begin
        data_o = rf_data_i;
        if (addr_i != '0) begin
            if (exmem_wr_i && (exmem_addr_i == addr_i)) begin
                data_o = exmem_data_i;
            end else if (memwb_wr_i && (memwb_addr_i == addr_i)) begin
                data_o = memwb_data_i;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage with forwarding and 2-entry skid buffer; optional ALU_ISSUE_PERF_EN adds perf_stall_o
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              alu_src_i,
    input  logic [CTRL_W-1:0] alu_ctrl_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              exmem_wr_i,
    input  logic [REG_AW-1:0] exmem_addr_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_wr_i,
    input  logic [REG_AW-1:0] memwb_addr_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_stall_o
`endif
);

    state_e            state_q, state_d;
    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    entry_t            in_entry;
    logic              in_ready_q, in_ready_d;
    logic              out_valid;
    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    alu_issue_stage_fwd_mux u_fwd_rs (
        .addr_i       (rs_addr_i),
        .rf_data_i    (rs_data_i),
        .exmem_wr_i   (exmem_wr_i),
        .exmem_addr_i (exmem_addr_i),
        .exmem_data_i (exmem_data_i),
        .memwb_wr_i   (memwb_wr_i),
        .memwb_addr_i (memwb_addr_i),
        .memwb_data_i (memwb_data_i),
        .data_o       (rs_fwd)
    );

    alu_issue_stage_fwd_mux u_fwd_rt (
        .addr_i       (rt_addr_i),
        .rf_data_i    (rt_data_i),
        .exmem_wr_i   (exmem_wr_i),
        .exmem_addr_i (exmem_addr_i),
        .exmem_data_i (exmem_data_i),
        .memwb_wr_i   (memwb_wr_i),
        .memwb_addr_i (memwb_addr_i),
        .memwb_data_i (memwb_data_i),
        .data_o       (rt_fwd)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid_i && in_ready_q;
    assign consume   = out_valid && out_ready_i;

    // Resolve operands once, at capture; held entries are never re-forwarded.
    always_comb begin
        in_entry.src1      = rs_fwd;
        in_entry.src2      = alu_src_i ? imm_i : rt_fwd;
        in_entry.ctrl      = alu_ctrl_i;
        in_entry.rd        = rd_addr_i;
        in_entry.reg_write = reg_write_i;
    end

    // Skid FSM: main drives the ALU, skid absorbs the one instruction accepted while stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_TWO;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d          = ST_EMPTY;
            main_d.reg_write = 1'b0;
            skid_d.reg_write = 1'b0;
        end
        // Registered ready: depends only on where we are going, never on out_ready_i directly.
        in_ready_d = (state_d != ST_TWO);
    end

    // State and entry registers; reset clears data as well as control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid;
    assign src1_o      = main_q.src1;
    assign src2_o      = main_q.src2;
    assign ctrl_o      = main_q.ctrl;
    assign rd_addr_o   = main_q.rd;
    assign reg_write_o = main_q.reg_write;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of cycles the ALU side holds off a valid instruction.
    always_comb begin
        perf_d = perf_q;
        if (out_valid && !out_ready_i && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter survives flush; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_o = perf_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage (also covers ALU_ISSUE_PERF_EN when defined)
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic              clk;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic              alu_src_i;
    logic [CTRL_W-1:0] alu_ctrl_i;
    logic [REG_AW-1:0] rs_addr_i;
    logic [REG_AW-1:0] rt_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              reg_write_i;
    logic              exmem_wr_i;
    logic [REG_AW-1:0] exmem_addr_i;
    logic [DATA_W-1:0] exmem_data_i;
    logic              memwb_wr_i;
    logic [REG_AW-1:0] memwb_addr_i;
    logic [DATA_W-1:0] memwb_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_write_o;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]       perf_stall_o;
`endif

    int     checks;
    int     errors;
    int     consumed;
    entry_t sb_q[$];

    alu_issue_stage dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_i        (imm_i),
        .alu_src_i    (alu_src_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rd_addr_i    (rd_addr_i),
        .reg_write_i  (reg_write_i),
        .exmem_wr_i   (exmem_wr_i),
        .exmem_addr_i (exmem_addr_i),
        .exmem_data_i (exmem_data_i),
        .memwb_wr_i   (memwb_wr_i),
        .memwb_addr_i (memwb_addr_i),
        .memwb_data_i (memwb_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .src1_o       (src1_o),
        .src2_o       (src2_o),
        .ctrl_o       (ctrl_o),
        .rd_addr_o    (rd_addr_o),
        .reg_write_o  (reg_write_o)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_stall_o (perf_stall_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (rst_i)
        (out_valid_o && !out_ready_i && !flush_i) |=>
        (out_valid_o && $stable(src1_o) && $stable(src2_o) && $stable(ctrl_o)
         && $stable(rd_addr_o) && $stable(reg_write_o)))
    else $display("FAIL hold_stable: outputs changed while stalled, src1=%h src2=%h", src1_o, src2_o);

    function automatic logic [DATA_W-1:0] model_fwd(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] rf);
        if (a != 0 && exmem_wr_i && exmem_addr_i == a) return exmem_data_i;
        if (a != 0 && memwb_wr_i && memwb_addr_i == a) return memwb_data_i;
        return rf;
    endfunction

    task automatic tick();
        entry_t exp;
        entry_t got;
        @(negedge clk);
        if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            consumed++;
            checks++;
            got.src1      = src1_o;
            got.src2      = src2_o;
            got.ctrl      = ctrl_o;
            got.rd        = rd_addr_o;
            got.reg_write = reg_write_o;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got src1=%h src2=%h rd=%0d, required no output", got.src1, got.src2, got.rd);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_entry: got src1=%h src2=%h ctrl=%h rd=%0d rw=%b, required src1=%h src2=%h ctrl=%h rd=%0d rw=%b",
                             got.src1, got.src2, got.ctrl, got.rd, got.reg_write,
                             exp.src1, exp.src2, exp.ctrl, exp.rd, exp.reg_write);
                end
            end
        end
        if (rst_i || flush_i) begin
            sb_q.delete();
        end else if (in_valid_i && in_ready_o) begin
            exp.src1      = model_fwd(rs_addr_i, rs_data_i);
            exp.src2      = alu_src_i ? imm_i : model_fwd(rt_addr_i, rt_data_i);
            exp.ctrl      = alu_ctrl_i;
            exp.rd        = rd_addr_i;
            exp.reg_write = reg_write_i;
            sb_q.push_back(exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                          input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd, input logic [DATA_W-1:0] imm,
                          input logic src, input logic [CTRL_W-1:0] ctrl, input logic rw);
        rs_addr_i   = rs;
        rt_addr_i   = rt;
        rd_addr_i   = rd;
        rs_data_i   = rsd;
        rt_data_i   = rtd;
        imm_i       = imm;
        alu_src_i   = src;
        alu_ctrl_i  = ctrl;
        reg_write_i = rw;
    endtask

    task automatic send(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                        input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd, input logic [DATA_W-1:0] imm,
                        input logic src, input logic [CTRL_W-1:0] ctrl, input logic rw);
        logic ok;
        set_in(rs, rt, rd, rsd, rtd, imm, src, ctrl, rw);
        in_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ok = in_ready_o;
            tick();
            if (ok) break;
        end
        in_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready_o=%b after 20 cycles, required 1", in_ready_o);
        end
    endtask

    task automatic drain();
        logic done;
        out_ready_i = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0 && out_valid_o !== 1'b1) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: %0d entries pending, out_valid_o=%b, required 0 and 0", sb_q.size(), out_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || src1_o !== '0 || src2_o !== '0 ||
            ctrl_o !== '0 || rd_addr_o !== '0 || reg_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b ready=%b src1=%h src2=%h ctrl=%h rd=%0d rw=%b, required 0 1 0 0 0 0 0",
                     out_valid_o, in_ready_o, src1_o, src2_o, ctrl_o, rd_addr_o, reg_write_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_forward();
        out_ready_i  = 1'b1;
        exmem_wr_i   = 1'b1; exmem_addr_i = 5'd5; exmem_data_i = 32'h11;
        memwb_wr_i   = 1'b1; memwb_addr_i = 5'd5; memwb_data_i = 32'h22;
        send(5'd5, 5'd0, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1);
        checks++;
        if (src1_o !== 32'h11) begin
            errors++;
            $display("FAIL fwd_exmem_priority: src1_o=%h, required 00000011", src1_o);
        end
        exmem_addr_i = 5'd0; memwb_addr_i = 5'd0;
        send(5'd0, 5'd0, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0, ALU_OR, 1'b1);
        checks++;
        if (src1_o !== 32'h33) begin
            errors++;
            $display("FAIL fwd_reg0: src1_o=%h, required 00000033", src1_o);
        end
        exmem_addr_i = 5'd6; memwb_addr_i = 5'd5;
        send(5'd5, 5'd0, 5'd4, 32'h33, 32'h0, 32'h0, 1'b0, ALU_AND, 1'b0);
        checks++;
        if (src1_o !== 32'h22) begin
            errors++;
            $display("FAIL fwd_memwb: src1_o=%h, required 00000022", src1_o);
        end
        exmem_wr_i = 1'b0; exmem_addr_i = 5'd9; memwb_addr_i = 5'd9; memwb_data_i = 32'h44;
        send(5'd1, 5'd9, 5'd2, 32'h1, 32'h55, 32'h0, 1'b0, ALU_SLT, 1'b1);
        checks++;
        if (src2_o !== 32'h44) begin
            errors++;
            $display("FAIL fwd_rt_memwb: src2_o=%h, required 00000044", src2_o);
        end
        memwb_wr_i = 1'b0;
    endtask

    task automatic test_immediate();
        out_ready_i  = 1'b1;
        exmem_wr_i   = 1'b1; exmem_addr_i = 5'd7; exmem_data_i = 32'hDEAD;
        send(5'd1, 5'd7, 5'd4, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, ALU_SUB, 1'b1);
        checks++;
        if (src2_o !== 32'hFFFF_FFF0 || ctrl_o !== ALU_SUB) begin
            errors++;
            $display("FAIL imm_select: src2_o=%h ctrl_o=%h, required fffffff0 %h", src2_o, ctrl_o, ALU_SUB);
        end
        exmem_wr_i = 1'b0;
        drain();
    endtask

    task automatic test_back_pressure();
        logic ok;
        int   base;
        base = consumed;
        out_ready_i = 1'b0;
        send(5'd1, 5'd2, 5'd10, 32'hA, 32'hA0, 32'h0, 1'b0, ALU_ADD, 1'b1);
        send(5'd1, 5'd2, 5'd11, 32'hB, 32'hB0, 32'h0, 1'b0, ALU_MUL, 1'b1);
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || src1_o !== 32'hA) begin
            errors++;
            $display("FAIL bp_full: in_ready_o=%b out_valid_o=%b src1_o=%h, required 0 1 0000000a", in_ready_o, out_valid_o, src1_o);
        end
        set_in(5'd1, 5'd2, 5'd12, 32'hC, 32'hC0, 32'h0, 1'b0, ALU_NOR, 1'b0);
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready_o !== 1'b0 || src1_o !== 32'hA) begin
                errors++;
                $display("FAIL bp_hold: in_ready_o=%b src1_o=%h, required 0 0000000a", in_ready_o, src1_o);
            end
        end
        out_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ok = in_ready_o;
            tick();
            if (ok) break;
        end
        in_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_c_accept: in_ready_o=%b, required 1 after release", in_ready_o);
        end
        drain();
        checks++;
        if (consumed - base !== 3) begin
            errors++;
            $display("FAIL bp_count: emitted %0d, required 3", consumed - base);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(5'd3, 5'd4, 5'(i), 32'(100 + i), 32'(200 + i), 32'h0, 1'b0, ALU_ADD, 1'b1);
            in_valid_i = 1'b1;
            checks++;
            if (in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: beat %0d in_ready_o=%b, required 1", i, in_ready_o);
            end
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || src1_o !== 32'(100 + i)) begin
                errors++;
                $display("FAIL b2b_valid: beat %0d out_valid_o=%b src1_o=%h, required 1 %h", i, out_valid_o, src1_o, 32'(100 + i));
            end
        end
        in_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        send(5'd1, 5'd2, 5'd13, 32'h1A, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1);
        send(5'd1, 5'd2, 5'd14, 32'h1B, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1);
        set_in(5'd1, 5'd2, 5'd15, 32'h1D, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1);
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || reg_write_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_two: out_valid_o=%b in_ready_o=%b reg_write_o=%b, required 0 1 0", out_valid_o, in_ready_o, reg_write_o);
        end
        out_ready_i = 1'b1;
        send(5'd1, 5'd2, 5'd16, 32'h1E, 32'h0, 32'h0, 1'b0, ALU_OR, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || src1_o !== 32'h1E || rd_addr_o !== 5'd16) begin
            errors++;
            $display("FAIL flush_next: out_valid_o=%b src1_o=%h rd=%0d, required 1 0000001e 16", out_valid_o, src1_o, rd_addr_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_one: out_valid_o=%b, required 0", out_valid_o);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b0;
        send(5'd1, 5'd2, 5'd20, 32'h5A, 32'h5B, 32'h0, 1'b0, ALU_SUB, 1'b1);
        send(5'd1, 5'd2, 5'd21, 32'h6A, 32'h6B, 32'h0, 1'b0, ALU_SUB, 1'b1);
        tick();
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || src1_o !== 32'h5A) begin
            errors++;
            $display("FAIL rst_pre_two: in_ready_o=%b src1_o=%h, required 0 0000005a", in_ready_o, src1_o);
        end
`ifdef ALU_ISSUE_PERF_EN
        checks++;
        if (perf_stall_o !== 32'd3) begin
            errors++;
            $display("FAIL perf_count: perf_stall_o=%0d, required 3", perf_stall_o);
        end
`endif
        rst_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || src1_o !== '0 || src2_o !== '0 ||
            ctrl_o !== '0 || rd_addr_o !== '0 || reg_write_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_midstream: valid=%b ready=%b src1=%h src2=%h ctrl=%h rd=%0d rw=%b, required 0 1 0 0 0 0 0",
                     out_valid_o, in_ready_o, src1_o, src2_o, ctrl_o, rd_addr_o, reg_write_o);
        end
`ifdef ALU_ISSUE_PERF_EN
        checks++;
        if (perf_stall_o !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: perf_stall_o=%0d, required 0", perf_stall_o);
        end
`endif
        rst_i = 1'b0;
        drain();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        consumed     = 0;
        rst_i        = 1'b1;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b0;
        exmem_wr_i   = 1'b0;
        exmem_addr_i = '0;
        exmem_data_i = '0;
        memwb_wr_i   = 1'b0;
        memwb_addr_i = '0;
        memwb_data_i = '0;
        set_in('0, '0, '0, '0, '0, '0, 1'b0, ALU_AND, 1'b0);

        test_reset();
        test_forward();
        test_immediate();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage sitting directly upstream of the ALU.
- Accepts decoded instructions from the decode stage and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects the immediate when required, then presents registered src1/src2/ctrl to the ALU.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so decode back-pressure never loses an instruction and throughput stays at one instruction per cycle.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- CTRL_W, 4, ALU control width (matches ALU ctrl encoding).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous flush (branch taken); drops all buffered entries.
- in_valid_i  in  1  decode has an instruction.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- rs_data_i  in  DATA_W  register-file read data for rs.
- rt_data_i  in  DATA_W  register-file read data for rt.
- imm_i  in  DATA_W  sign/zero-extended immediate.
- alu_src_i  in  1  1 = src2 takes imm_i, 0 = src2 takes rt.
- alu_ctrl_i  in  CTRL_W  ALU operation code.
- rs_addr_i  in  REG_AW  rs register number.
- rt_addr_i  in  REG_AW  rt register number.
- rd_addr_i  in  REG_AW  destination register number.
- reg_write_i  in  1  instruction writes back.
- exmem_wr_i  in  1  EX/MEM forwarding source write enable.
- exmem_addr_i  in  REG_AW  EX/MEM forwarding source address.
- exmem_data_i  in  DATA_W  EX/MEM forwarding source data.
- memwb_wr_i  in  1  MEM/WB forwarding source write enable.
- memwb_addr_i  in  REG_AW  MEM/WB forwarding source address.
- memwb_data_i  in  DATA_W  MEM/WB forwarding source data.
- out_valid_o  out  1  src/ctrl outputs hold a valid instruction.
- out_ready_i  in  1  ALU/EX side consumes this cycle.
- src1_o  out  DATA_W  ALU operand 1.
- src2_o  out  DATA_W  ALU operand 2.
- ctrl_o  out  CTRL_W  ALU ctrl.
- rd_addr_o  out  REG_AW  destination passed down the pipe.
- reg_write_o  out  1  write-back enable passed down the pipe.

Behaviour:
- Reset/clocking: one clock (clk_i); rst_i is synchronous and active-high. Priority is rst_i > flush_i > handshake.
- Reset values: state EMPTY, out_valid_o=0, in_ready_o=1, src1_o=src2_o=0, ctrl_o=0, rd_addr_o=0, reg_write_o=0.
- Forwarding (combinational, evaluated on the capture cycle only) for each of rs and rt:
  - EX/MEM is selected if exmem_wr_i and exmem_addr_i == addr and addr != 0.
  - Otherwise MEM/WB under the same rule.
  - Otherwise the register-file data.
  - EX/MEM wins when both sources match; register 0 is never forwarded.
- Operand select: src2 = alu_src_i ? imm_i : forwarded rt. Each entry stores resolved src1, src2, ctrl, rd, reg_write.
- Stall hazards: operands are frozen at capture. Load-use stalls are the hazard unit's job; this stage does not re-forward held entries.
- Entries: main register (drives outputs) and skid register.
- States and transitions:
  - EMPTY: accept -> ONE (into main).
  - ONE: accept && consume -> ONE (new data into main); accept && !consume -> TWO (new data into skid); consume only -> EMPTY.
  - TWO: consume -> ONE (skid moves to main).
- in_ready_o is registered: 1 iff the next state != TWO. There is no combinational path from out_ready_i to in_ready_o.
- Definitions: accept = in_valid_i && in_ready_o; consume = out_valid_o && out_ready_i.
- Latency: 1 cycle from accept to out_valid_o when empty. Sustained throughput is 1/cycle while out_ready_i=1.
- Outputs hold stable while out_valid_o && !out_ready_i (verify with an assertion).
- flush_i: next state EMPTY, out_valid_o=0, in_ready_o=1. A same-cycle input is discarded and a same-cycle consume still counts. Data registers need not clear; reg_write_o is forced to 0.
- Reset mid-stream behaves like flush, plus all data is cleared.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds output perf_stall_o [31:0], counting cycles with out_valid_o && !out_ready_i. It saturates at 0xFFFFFFFF, clears on rst_i, and is unaffected by flush_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: DATA_W, REG_AW, CTRL_W, and the ALU ctrl opcode constants (AND 0000, OR 0001, ADD 0010, MUL 0011, SUB 0110, SLT 0111, NOR 1100).
- Also in the package: the state enum {EMPTY, ONE, TWO} and a packed entry struct {src1, src2, ctrl, rd, reg_write}.
- One sub-module: fwd_mux (combinational forwarding select for one operand), instantiated twice.

Test Plan:
- Forward priority: rs_addr=5, exmem (wr=1, addr=5, data=0x11), memwb (wr=1, addr=5, data=0x22), rs_data=0x33 -> src1_o=0x11 one cycle later. Same with addr=0 -> src1_o=0x33.
- Immediate path: alu_src=1, imm=0xFFFFFFF0, rt fwd active -> src2_o=0xFFFFFFF0, ctrl_o equals input ctrl.
- Back-pressure: stream A, B, C with out_ready_i=0 from cycle 1 -> state TWO, in_ready_o=0, C held upstream, src1_o stays A. Release -> A, B, C emitted in order, no drop or duplicate.
- Full throughput: 8 back-to-back instructions with out_ready_i=1 -> 8 consecutive out_valid cycles, in_ready_o constant 1.
- Flush in TWO with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, reg_write_o=0. The following instruction is issued normally.
- Reset mid-stream (TWO) -> all outputs at reset values next cycle. With ALU_ISSUE_PERF_EN, 3 stall cycles beforehand read 3, then 0 after reset.
